// File: rtl/br_puf_eval.sv
// Evaluation controller for a bistable ring PUF: pulses the ring reset, samples the
// settled ring output NEVAL times, majority-votes a response and hands it off valid/ready.
module br_puf_eval #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned RESET_CYCLES  = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned NEVAL         = 3,
  parameter int unsigned CW            = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] C,
  output logic             BUSY,
  output logic [WIDTH-1:0] RING_C,
  output logic             RING_RESET,
  input  logic             RING_OUT,
  output logic             RESP,
  output logic             STABLE,
  output logic [CW-1:0]    ONES,
  output logic             RESP_VALID,
  input  logic             RESP_READY
);

  localparam int unsigned PMAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW   = $clog2(PMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PULSE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CW-1:0]    eval_q, eval_d;
  logic [CW-1:0]    ones_q, ones_d;
  logic [WIDTH-1:0] ring_c_q, ring_c_d;
  logic             ring_reset_q, ring_reset_d;
  logic             busy_q, busy_d;
  logic             resp_q, resp_d;
  logic             stable_q, stable_d;
  logic             resp_valid_q, resp_valid_d;
  logic             sync1_q, sync2_q;

  // Two-flop synchroniser for the asynchronous ring output
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= RING_OUT;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      eval_q       <= '0;
      ones_q       <= '0;
      ring_c_q     <= '0;
      ring_reset_q <= 1'b0;
      busy_q       <= 1'b0;
      resp_q       <= 1'b0;
      stable_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      eval_q       <= eval_d;
      ones_q       <= ones_d;
      ring_c_q     <= ring_c_d;
      ring_reset_q <= ring_reset_d;
      busy_q       <= busy_d;
      resp_q       <= resp_d;
      stable_q     <= stable_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Next state; the response is registered in the first DONE cycle, once ONES holds the last sample
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    eval_d       = eval_q;
    ones_d       = ones_q;
    ring_c_d     = ring_c_q;
    resp_d       = resp_q;
    stable_d     = stable_q;
    resp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          ring_c_d = C;
          ones_d   = '0;
          eval_d   = '0;
          tmr_d    = '0;
          resp_d   = 1'b0;
          stable_d = 1'b0;
          state_d  = S_PULSE;
        end
      end
      S_PULSE: begin
        if (tmr_q == TW'(RESET_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_SETTLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_SETTLE: begin
        if (tmr_q == TW'(SETTLE_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_SAMPLE: begin
        ones_d  = ones_q + CW'(sync2_q);
        eval_d  = eval_q + CW'(1);
        state_d = (eval_d == CW'(NEVAL)) ? S_DONE : S_PULSE;
      end
      S_DONE: begin
        if (resp_valid_q && RESP_READY) begin
          state_d = S_IDLE;
        end else begin
          resp_valid_d = 1'b1;
          if (!resp_valid_q) begin
            resp_d   = (ones_q > CW'(NEVAL / 2));
            stable_d = (ones_q == '0) || (ones_q == CW'(NEVAL));
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ring_reset_d = (state_d == S_PULSE);
    busy_d       = (state_d != S_IDLE) && !resp_valid_d;
  end

  assign BUSY       = busy_q;
  assign RING_C     = ring_c_q;
  assign RING_RESET = ring_reset_q;
  assign RESP       = resp_q;
  assign STABLE     = stable_q;
  assign ONES       = ones_q;
  assign RESP_VALID = resp_valid_q;

endmodule

// File: tb/tb_br_puf_eval.sv
// Bench for br_puf_eval: default instance plus a small-parameter instance, randomized
// challenges and ring patterns checked against a latency/majority-vote reference model.
module tb_br_puf_eval;

  logic         CLK;
  logic         RESET;
  logic         START, RING_OUT, RESP_READY;
  logic [63:0]  C;
  logic         BUSY, RING_RESET, RESP, STABLE, RESP_VALID;
  logic [63:0]  RING_C;
  logic [7:0]   ONES;

  logic         START6, RING_OUT6, RESP_READY6;
  logic [127:0] C6;
  logic         BUSY6, RING_RESET6, RESP6, STABLE6, RESP_VALID6;
  logic [127:0] RING_C6;
  logic [7:0]   ONES6;

  int vectors;
  int miscompares;

  logic [63:0] exp_c;
  int          exp_ones;
  logic        exp_resp, exp_stable;

  br_puf_eval dut (
    .CLK(CLK), .RESET(RESET), .START(START), .C(C), .BUSY(BUSY), .RING_C(RING_C),
    .RING_RESET(RING_RESET), .RING_OUT(RING_OUT), .RESP(RESP), .STABLE(STABLE),
    .ONES(ONES), .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY)
  );

  br_puf_eval #(.WIDTH(128), .RESET_CYCLES(1), .SETTLE_CYCLES(2), .NEVAL(5), .CW(8)) dut6 (
    .CLK(CLK), .RESET(RESET), .START(START6), .C(C6), .BUSY(BUSY6), .RING_C(RING_C6),
    .RING_RESET(RING_RESET6), .RING_OUT(RING_OUT6), .RESP(RESP6), .STABLE(STABLE6),
    .ONES(ONES6), .RESP_VALID(RESP_VALID6), .RESP_READY(RESP_READY6)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 12; i++) begin
      if (i == 2) RESET = 1'b0;
      step();
      vectors++;
      if ({BUSY, RING_RESET, RESP, STABLE, RESP_VALID} !== 5'b0 || ONES !== 8'd0 || RING_C !== 64'd0) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: got busy/rr/resp/stb/vld=%b ones=%0d ring_c=%h required all 0",
                 i, {BUSY, RING_RESET, RESP, STABLE, RESP_VALID}, ONES, RING_C);
      end
    end
  endtask

  // Accept, run to RESP_VALID with cycle-by-cycle checks, leave response pending
  task automatic run_eval(input logic [63:0] c, input logic [2:0] bits);
    logic exp_rr;
    exp_c      = c;
    exp_ones   = int'(bits[0]) + int'(bits[1]) + int'(bits[2]);
    exp_resp   = (exp_ones > 1);
    exp_stable = (exp_ones == 0) || (exp_ones == 3);
    START = 1'b1;
    C     = c;
    step();
    START = 1'b0;
    for (int n = 0; n <= 64; n++) begin
      if (n < 63 && (n % 21) == 0) RING_OUT = bits[n / 21];
      C = {$urandom, $urandom};
      exp_rr = (n < 63) && ((n % 21) < 4);
      vectors++;
      if (RING_C !== c) begin
        miscompares++; $display("FAIL ring_c n=%0d: got %h required %h", n, RING_C, c);
      end
      vectors++;
      if (RING_RESET !== exp_rr) begin
        miscompares++; $display("FAIL ring_reset n=%0d: got %b required %b", n, RING_RESET, exp_rr);
      end
      vectors++;
      if (RESP_VALID !== (n == 64) || BUSY !== (n < 64)) begin
        miscompares++;
        $display("FAIL latency n=%0d: got valid=%b busy=%b required valid=%b busy=%b",
                 n, RESP_VALID, BUSY, (n == 64), (n < 64));
      end
      if (n < 64) step();
    end
    vectors++;
    if (RESP !== exp_resp || STABLE !== exp_stable || int'(ONES) != exp_ones) begin
      miscompares++;
      $display("FAIL result bits=%b: got resp=%b stable=%b ones=%0d required resp=%b stable=%b ones=%0d",
               bits, RESP, STABLE, ONES, exp_resp, exp_stable, exp_ones);
    end
  endtask

  task automatic test_handshake(input logic start_in_hs);
    RESP_READY = 1'b1;
    START      = start_in_hs;
    step();
    RESP_READY = 1'b0;
    START      = 1'b0;
    vectors++;
    if (RESP_VALID !== 1'b0 || BUSY !== 1'b0) begin
      miscompares++; $display("FAIL handshake_drop: got valid=%b busy=%b required 0 0", RESP_VALID, BUSY);
    end
    vectors++;
    if (RESP !== exp_resp || STABLE !== exp_stable || int'(ONES) != exp_ones) begin
      miscompares++;
      $display("FAIL handshake_hold: got resp=%b stable=%b ones=%0d required %b %b %0d",
               RESP, STABLE, ONES, exp_resp, exp_stable, exp_ones);
    end
    step();
    vectors++;
    if (BUSY !== 1'b0 || RING_RESET !== 1'b0) begin
      miscompares++; $display("FAIL idle_after_hs: got busy=%b rr=%b required 0 0", BUSY, RING_RESET);
    end
  endtask

  task automatic test_constant_one();
    RING_OUT = 1'b1;
    run_eval(64'hDEADBEEF_0123_4567, 3'b111);
    test_handshake(1'b0);
  endtask

  task automatic test_mixed_samples();
    run_eval({$urandom, $urandom}, 3'b101);
    test_handshake(1'b0);
    run_eval({$urandom, $urandom}, 3'b100);
    test_handshake(1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_eval({$urandom, $urandom}, 3'($urandom_range(0, 7)));
      test_handshake(1'b0);
    end
  endtask

  task automatic test_back_to_back_backpressure();
    run_eval({$urandom, $urandom}, 3'($urandom_range(0, 7)));
    for (int i = 0; i < 20; i++) begin
      START = (i % 3 == 0);
      step();
      vectors++;
      if (RESP_VALID !== 1'b1 || BUSY !== 1'b0 || RING_RESET !== 1'b0 || RING_C !== exp_c) begin
        miscompares++;
        $display("FAIL backpressure_ctl i=%0d: got valid=%b busy=%b rr=%b ring_c=%h required 1 0 0 %h",
                 i, RESP_VALID, BUSY, RING_RESET, RING_C, exp_c);
      end
      vectors++;
      if (RESP !== exp_resp || STABLE !== exp_stable || int'(ONES) != exp_ones) begin
        miscompares++;
        $display("FAIL backpressure_hold i=%0d: got resp=%b stable=%b ones=%0d required %b %b %0d",
                 i, RESP, STABLE, ONES, exp_resp, exp_stable, exp_ones);
      end
    end
    test_handshake(1'b1);
  endtask

  task automatic test_reset_mid_eval();
    START = 1'b1;
    C     = {$urandom, $urandom};
    step();
    START = 1'b0;
    repeat (22) step();
    vectors++;
    if (RING_RESET !== 1'b1) begin
      miscompares++; $display("FAIL second_pulse: got rr=%b required 1", RING_RESET);
    end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    vectors++;
    if (RING_RESET !== 1'b0 || BUSY !== 1'b0 || RESP_VALID !== 1'b0 || ONES !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got rr=%b busy=%b valid=%b ones=%0d required 0 0 0 0",
               RING_RESET, BUSY, RESP_VALID, ONES);
    end
    for (int i = 0; i < 70; i++) begin
      step();
      vectors++;
      if (RESP_VALID !== 1'b0 || BUSY !== 1'b0 || RING_RESET !== 1'b0) begin
        miscompares++;
        $display("FAIL aborted_quiet i=%0d: got valid=%b busy=%b rr=%b required 0 0 0",
                 i, RESP_VALID, BUSY, RING_RESET);
      end
    end
    run_eval({$urandom, $urandom}, 3'($urandom_range(0, 7)));
    test_handshake(1'b0);
  endtask

  // Small instance: 5 evaluations of 4 cycles each plus one cycle to register the vote
  task automatic run_eval6(input logic [127:0] c, input logic [4:0] bits);
    int   ones;
    logic rr;
    ones = 0;
    for (int k = 0; k < 5; k++) ones += int'(bits[k]);
    START6 = 1'b1;
    C6     = c;
    step();
    START6 = 1'b0;
    for (int n = 0; n <= 21; n++) begin
      if (n < 20 && (n % 4) == 0) RING_OUT6 = bits[n / 4];
      C6 = {$urandom, $urandom, $urandom, $urandom};
      rr = (n < 20) && ((n % 4) == 0);
      vectors++;
      if (RING_C6 !== c || RING_RESET6 !== rr) begin
        miscompares++;
        $display("FAIL p6_ring n=%0d: got ring_c=%h rr=%b required %h %b", n, RING_C6, RING_RESET6, c, rr);
      end
      vectors++;
      if (RESP_VALID6 !== (n == 21) || BUSY6 !== (n < 21)) begin
        miscompares++;
        $display("FAIL p6_latency n=%0d: got valid=%b busy=%b required %b %b",
                 n, RESP_VALID6, BUSY6, (n == 21), (n < 21));
      end
      if (n < 21) step();
    end
    vectors++;
    if (RESP6 !== (ones > 2) || STABLE6 !== (ones == 0 || ones == 5) || int'(ONES6) != ones) begin
      miscompares++;
      $display("FAIL p6_result bits=%b: got resp=%b stable=%b ones=%0d required %b %b %0d",
               bits, RESP6, STABLE6, ONES6, (ones > 2), (ones == 0 || ones == 5), ones);
    end
    RESP_READY6 = 1'b1;
    step();
    RESP_READY6 = 1'b0;
    vectors++;
    if (RESP_VALID6 !== 1'b0 || BUSY6 !== 1'b0) begin
      miscompares++; $display("FAIL p6_handshake: got valid=%b busy=%b required 0 0", RESP_VALID6, BUSY6);
    end
  endtask

  task automatic test_params();
    run_eval6({$urandom, $urandom, $urandom, $urandom}, 5'b10101);
    for (int k = 0; k < 4; k++)
      run_eval6({$urandom, $urandom, $urandom, $urandom}, 5'($urandom_range(0, 31)));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    RESET       = 1'b1;
    START       = 1'b0;
    C           = '0;
    RING_OUT    = 1'b0;
    RESP_READY  = 1'b0;
    START6      = 1'b0;
    C6          = '0;
    RING_OUT6   = 1'b0;
    RESP_READY6 = 1'b0;

    test_reset();
    test_constant_one();
    test_mixed_samples();
    test_random();
    test_back_to_back_backpressure();
    test_reset_mid_eval();
    test_params();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
